// File: rtl/act_serializer_pkg.sv
// Shared accelerator constants for the activation serializer: default width,
// FSM encoding and the precision clamp target.
package act_serializer_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int PREC_W     = 4;

  // Out-of-range precision (0 or above the word width) falls back to full width.
  localparam int PREC_CLAMP_DEF = DATA_W_DEF;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } ser_state_t;

endpackage

// File: rtl/act_serializer.sv
// Parallel-to-serial activation converter feeding act_fifo one bit per write,
// LSB first, with a one-entry holding register for bubble-free word chaining.
module act_serializer
  import act_serializer_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [PREC_W-1:0] precision,
  input  logic              fifo_full,
  output logic              wr_en,
  output logic              dout,
  output logic              word_done,
  output logic              busy
);

  localparam int CW = $clog2(DATA_W + 1);

  ser_state_t        state, state_nx;
  logic              hold_valid;
  logic [DATA_W-1:0] hold_data;
  logic [CW-1:0]     hold_prec;
  logic [DATA_W-1:0] shreg;
  logic [CW-1:0]     sh_prec;
  logic [CW-1:0]     bit_cnt;
  logic [CW-1:0]     prec_cl;
  logic              accept, shift_en, last, load;

  always_comb begin
    prec_cl = CW'(DATA_W);
    if (precision != '0 && int'(precision) <= DATA_W)
      prec_cl = CW'(precision);
  end

  // in_ready depends only on registered state, so clear is folded in here.
  assign accept   = in_valid && !hold_valid && !clear;
  assign shift_en = (state == ST_SHIFT) && !fifo_full;
  assign last     = (bit_cnt == sh_prec - CW'(1));
  assign load     = hold_valid && ((state == ST_IDLE) || (shift_en && last));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (hold_valid) state_nx = ST_SHIFT;
      ST_SHIFT: if (shift_en && last && !hold_valid) state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
    if (clear) state_nx = ST_IDLE;
  end

  always_comb begin
    in_ready = !hold_valid;
    wr_en    = shift_en;
    dout     = (state == ST_SHIFT) && shreg[0];
    busy     = hold_valid || (state == ST_SHIFT);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_valid <= 1'b0;
      hold_data  <= '0;
      hold_prec  <= '0;
      shreg      <= '0;
      sh_prec    <= '0;
      bit_cnt    <= '0;
      word_done  <= 1'b0;
    end else if (clear) begin
      hold_valid <= 1'b0;
      hold_data  <= '0;
      hold_prec  <= '0;
      shreg      <= '0;
      sh_prec    <= '0;
      bit_cnt    <= '0;
      word_done  <= 1'b0;
    end else begin
      word_done <= shift_en && last;
      if (load) begin
        shreg   <= hold_data;
        sh_prec <= hold_prec;
        bit_cnt <= '0;
      end else if (shift_en) begin
        shreg   <= shreg >> 1;
        bit_cnt <= bit_cnt + CW'(1);
      end
      // accept and load are exclusive: accept needs the hold empty, load needs it full.
      if (accept) begin
        hold_valid <= 1'b1;
        hold_data  <= in_data;
        hold_prec  <= prec_cl;
      end else if (load) begin
        hold_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_act_serializer.sv
// Bench for act_serializer: directed scenarios plus random traffic checked
// against a word-queue scoreboard of expected serial bits.
module tb_act_serializer;
  import act_serializer_pkg::*;

  localparam int DW = 8;

  logic          clk = 1'b0, rst = 1'b0, clear = 1'b0, in_valid = 1'b0, fifo_full = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic [3:0]    precision = '0;
  logic          in_ready, wr_en, dout, word_done, busy;

  act_serializer #(.DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .precision(precision), .fifo_full(fifo_full), .wr_en(wr_en),
    .dout(dout), .word_done(word_done), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    int            prec;
    int            idx;
  } wrd_t;

  wrd_t        q[$];
  bit          done_exp, acc;
  int          total, bad;
  int          cyc, wr_cnt, done_cnt, first_wr, last_wr, acc_cyc, nlog;
  logic [63:0] blog;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int clampp(input logic [3:0] p);
    return (p == 4'd0 || int'(p) > DW) ? DW : int'(p);
  endfunction

  // One clock: check outputs at the falling edge, advance the model, return after the rising edge.
  task automatic cycle();
    wrd_t          h;
    logic [DW-1:0] d;
    @(negedge clk);
    cyc++;
    acc = 1'b0;
    if (!rst) begin
      chk("wr_in_rst", wr_en, 0);
    end else begin
      chk("word_done", word_done, done_exp);
      chk("busy", busy, q.size() != 0);
      chk("wr_when_full", wr_en & fifo_full, 0);
      if (q.size() == 0)      chk("rdy_empty", in_ready, 1);
      else if (q.size() >= 2) chk("rdy_full", in_ready, 0);
      done_exp = 1'b0;
      if (word_done) done_cnt++;
      if (wr_en) begin
        wr_cnt++;
        if (nlog < 64) blog[nlog] = dout;
        nlog++;
        if (first_wr < 0) first_wr = cyc;
        last_wr = cyc;
        if (q.size() == 0) chk("wr_no_data", wr_en, 0);
        else begin
          h = q[0];
          d = h.data;
          chk("dout", dout, d[h.idx]);
          h.idx++;
          if (h.idx == h.prec) begin
            void'(q.pop_front());
            done_exp = 1'b1;
          end else q[0] = h;
        end
      end
      if (in_valid && in_ready && !clear) begin
        q.push_back('{in_data, clampp(precision), 0});
        acc     = 1'b1;
        acc_cyc = cyc;
      end
      if (clear) begin
        q.delete();
        done_exp = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle();
  endtask

  task automatic send(input logic [DW-1:0] d, input logic [3:0] p);
    in_valid = 1'b1; in_data = d; precision = p;
    for (int i = 0; i < 50; i++) begin
      cycle();
      if (acc) break;
    end
    in_valid = 1'b0;
    chk("accept", acc, 1);
  endtask

  task automatic wait_wr(input int n);
    for (int i = 0; i < 100 && wr_cnt < n; i++) cycle();
    chk("wait_wr", wr_cnt >= n, 1);
  endtask

  task automatic clrlog();
    nlog = 0; blog = '0; first_wr = -1; last_wr = -1; wr_cnt = 0; done_cnt = 0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    int w, dn;
    int pl[2];
    total = 0; bad = 0; cyc = 0; done_exp = 1'b0;
    clrlog();

    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_dout", dout, 0);
    chk("rst_busy", busy, 0);
    chk("rst_word_done", word_done, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    idle(2);

    // single 8-bit word, latency and contiguity
    clrlog();
    send(8'hB5, 4'd8);
    idle(12);
    chk("b5_bits", blog[7:0], 8'hB5);
    chk("b5_count", wr_cnt, 8);
    chk("b5_latency", first_wr - acc_cyc, 2);
    chk("b5_contig", last_wr - first_wr, 7);
    chk("b5_done", done_cnt, 1);

    // back-to-back precision-2 words, no bubble
    clrlog();
    send(8'h03, 4'd2);
    send(8'h02, 4'd2);
    idle(8);
    chk("b2b_bits", blog[3:0], 4'hB);
    chk("b2b_count", wr_cnt, 4);
    chk("b2b_contig", last_wr - first_wr, 3);
    chk("b2b_done", done_cnt, 2);

    // downstream stall mid-word
    clrlog();
    send(8'hF0, 4'd8);
    wait_wr(2);
    fifo_full = 1'b1;
    w = wr_cnt;
    idle(3);
    chk("stall_wr", wr_cnt - w, 0);
    fifo_full = 1'b0;
    idle(12);
    chk("stall_bits", blog[7:0], 8'hF0);
    chk("stall_count", wr_cnt, 8);
    chk("stall_done", done_cnt, 1);

    // precision clamp
    pl[0] = 0; pl[1] = 12;
    for (int k = 0; k < 2; k++) begin
      clrlog();
      send(8'h81, 4'(pl[k]));
      idle(12);
      chk("clamp_bits", blog[7:0], 8'h81);
      chk("clamp_count", wr_cnt, 8);
    end

    // async reset mid-word with hold full
    clrlog();
    send(8'hA7, 4'd8);
    send(8'h5C, 4'd8);
    wait_wr(3);
    #2 rst = 1'b0;
    #1;
    chk("mrst_in_ready", in_ready, 1);
    chk("mrst_wr_en", wr_en, 0);
    chk("mrst_dout", dout, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_word_done", word_done, 0);
    q.delete(); done_exp = 1'b0;
    w = wr_cnt;
    idle(2);
    rst = 1'b1;
    idle(6);
    chk("mrst_no_wr", wr_cnt - w, 0);

    // synchronous clear in SHIFT with hold full
    clrlog();
    send(8'h6E, 4'd8);
    send(8'h39, 4'd8);
    idle(2);
    clear = 1'b1; in_valid = 1'b1; in_data = 8'hFF; precision = 4'd8;
    cycle();
    clear = 1'b0; in_valid = 1'b0;
    chk("clr_wr_en", wr_en, 0);
    chk("clr_busy", busy, 0);
    chk("clr_in_ready", in_ready, 1);
    dn = done_cnt; w = wr_cnt;
    idle(10);
    chk("clr_no_done", done_cnt - dn, 0);
    chk("clr_no_wr", wr_cnt - w, 0);

    // random traffic against the scoreboard
    for (int i = 0; i < 1500; i++) begin
      if (!in_valid || acc) begin
        in_valid  = ($urandom_range(0, 2) != 0);
        in_data   = DW'($urandom);
        precision = 4'($urandom_range(0, 15));
      end
      fifo_full = ($urandom_range(0, 3) == 0);
      clear     = ($urandom_range(0, 99) == 0);
      cycle();
    end
    in_valid = 1'b0; fifo_full = 1'b0; clear = 1'b0;
    for (int i = 0; i < 100 && q.size() != 0; i++) cycle();
    chk("drain", q.size(), 0);
    idle(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
